// File: rtl/inst_encoder_loader_pkg.sv
// rtl/inst_encoder_loader_pkg.sv - opcode constants, format/state enums and error codes
package inst_encoder_loader_pkg;

    localparam logic [4:0] OPCODE_LOAD    = 5'b00000;
    localparam logic [4:0] OPCODE_CUSTOM  = 5'b00010;
    localparam logic [4:0] OPCODE_ARITH_I = 5'b00100;
    localparam logic [4:0] OPCODE_AUIPC   = 5'b00101;
    localparam logic [4:0] OPCODE_STORE   = 5'b01000;
    localparam logic [4:0] OPCODE_ARITH_R = 5'b01100;
    localparam logic [4:0] OPCODE_LUI     = 5'b01101;
    localparam logic [4:0] OPCODE_BRANCH  = 5'b11000;
    localparam logic [4:0] OPCODE_JALR    = 5'b11001;
    localparam logic [4:0] OPCODE_JAL     = 5'b11011;
    localparam logic [4:0] OPCODE_SYSTEM  = 5'b11100;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_OPCODE = 2'b01;
    localparam logic [1:0] ERR_IMM    = 2'b10;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_WRITE, ST_FULL
    } state_e;

    function automatic fmt_e op_format(input logic [4:0] op);
        case (op)
            OPCODE_ARITH_R, OPCODE_CUSTOM:                           return FMT_R;
            OPCODE_LOAD, OPCODE_ARITH_I, OPCODE_JALR, OPCODE_SYSTEM: return FMT_I;
            OPCODE_STORE:                                            return FMT_S;
            OPCODE_BRANCH:                                           return FMT_B;
            OPCODE_LUI, OPCODE_AUIPC:                                return FMT_U;
            OPCODE_JAL:                                              return FMT_J;
            default:                                                 return FMT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/inst_encoder_loader_if.sv
// rtl/inst_encoder_loader_if.sv - descriptor input, imem write port and status bundle
interface inst_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic [1:0]        err_code;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  in_ready, wr_en, wr_addr, wr_data, count, full, err, err_code
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output in_ready, wr_en, wr_addr, wr_data, count, full, err, err_code
    );
endinterface

// File: rtl/inst_field_packer.sv
// rtl/inst_field_packer.sv - combinational RV32I word assembly and immediate range check
module inst_field_packer
    import inst_encoder_loader_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output fmt_e        fmt_o,
    output logic [31:0] word_o,
    output logic        imm_ok_o
);
    logic fits_12;
    logic fits_13;
    logic fits_21;

    // Signed fit: every bit above the top immediate bit must equal the sign.
    assign fits_12 = (imm_i[31:11] == {21{imm_i[31]}});
    assign fits_13 = (imm_i[31:12] == {20{imm_i[31]}});
    assign fits_21 = (imm_i[31:20] == {12{imm_i[31]}});

    always_comb begin
        fmt_o    = op_format(op_i);
        word_o   = '0;
        imm_ok_o = 1'b0;
        case (fmt_o)
            FMT_R: begin
                word_o   = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i, 2'b11};
                imm_ok_o = 1'b1;
            end
            FMT_I: begin
                word_o   = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i, 2'b11};
                imm_ok_o = fits_12;
            end
            FMT_S: begin
                word_o   = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i, 2'b11};
                imm_ok_o = fits_12;
            end
            FMT_B: begin
                word_o   = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], op_i, 2'b11};
                imm_ok_o = fits_13 && !imm_i[0];
            end
            FMT_U: begin
                word_o   = {imm_i[31:12], rd_i, op_i, 2'b11};
                imm_ok_o = (imm_i[11:0] == 12'h000);
            end
            FMT_J: begin
                word_o   = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i, 2'b11};
                imm_ok_o = fits_21 && !imm_i[0];
            end
            default: begin
                word_o   = '0;
                imm_ok_o = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/inst_encoder_loader.sv
// rtl/inst_encoder_loader.sv - accepts field descriptors and writes encoded words to imem
module inst_encoder_loader
    import inst_encoder_loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    inst_encoder_loader_if.slave  bus
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    state_e          state_q, state_d;
    logic [ADDR_W:0] count_q, count_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;

    fmt_e        fmt;
    logic [31:0] word;
    logic        imm_ok;
    logic        full;
    logic        in_ready;
    logic        accept;

    inst_field_packer u_packer (
        .op_i     (bus.in_op),
        .rd_i     (bus.in_rd),
        .rs1_i    (bus.in_rs1),
        .rs2_i    (bus.in_rs2),
        .funct3_i (bus.in_funct3),
        .funct7_i (bus.in_funct7),
        .imm_i    (bus.in_imm),
        .fmt_o    (fmt),
        .word_o   (word),
        .imm_ok_o (imm_ok)
    );

    assign full   = (count_q == DEPTH_C);
    assign accept = bus.in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_data_d  = wr_data_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        in_ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = !full && !clear;
                if (accept) begin
                    // Illegal descriptors complete the handshake but never reach imem.
                    if (fmt == FMT_BAD || !imm_ok) begin
                        err_d = 1'b1;
                        if (!err_q) err_code_d = (fmt == FMT_BAD) ? ERR_OPCODE : ERR_IMM;
                    end else begin
                        wr_data_d = word;
                        state_d   = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                count_d = count_q + ONE_C;
                state_d = (count_d == DEPTH_C) ? ST_FULL : ST_IDLE;
            end
            ST_FULL: state_d = ST_FULL;
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            count_d    = '0;
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
            state_d    = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // wr_en decodes the state register so an asynchronous reset kills it at once.
    assign bus.in_ready = in_ready;
    assign bus.wr_en    = (state_q == ST_WRITE);
    assign bus.wr_addr  = count_q[ADDR_W-1:0];
    assign bus.wr_data  = wr_data_q;
    assign bus.count    = count_q;
    assign bus.full     = full;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;
endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb/tb_inst_encoder_loader.sv - directed-vector bench for inst_encoder_loader
module tb_inst_encoder_loader;
    import inst_encoder_loader_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic clk;
    logic rst_n;
    logic clear;
    int   vectors;
    int   miscompares;

    inst_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_fields(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
        bus.in_op     = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
    endtask

    // Returns at the negedge of the cycle following the accepting edge.
    task automatic drive(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        @(negedge clk);
        set_fields(op, rd, rs1, rs2, f3, f7, imm);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; bus.in_valid = 1'b0;
        set_fields(5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.count, bus.full, bus.err, bus.err_code}
            !== {1'b1, 1'b0, 2'd0, 32'd0, 3'd0, 1'b0, 1'b0, 2'b00}) begin
            miscompares++;
            $display("FAIL reset: got rdy=%b wen=%b addr=%0d data=%h cnt=%0d full=%b err=%b code=%b required 1 0 0 0 0 0 0 00",
                     bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.count, bus.full, bus.err, bus.err_code);
        end
    endtask

    task automatic test_addi();
        drive(OPCODE_ARITH_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        vectors++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 2'd0, 32'h00500093}) begin
            miscompares++;
            $display("FAIL addi_write: got wen=%b addr=%0d data=%h required 1 0 00500093", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        @(negedge clk);
        vectors++;
        if ({bus.wr_en, bus.count, bus.in_ready} !== {1'b0, 3'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL addi_after: got wen=%b cnt=%0d rdy=%b required 0 1 1", bus.wr_en, bus.count, bus.in_ready);
        end
    endtask

    task automatic test_branch();
        drive(OPCODE_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
        vectors++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 2'd1, 32'hFE208EE3}) begin
            miscompares++;
            $display("FAIL beq_write: got wen=%b addr=%0d data=%h required 1 1 fe208ee3", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        drive(OPCODE_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4095);
        vectors++;
        if ({bus.wr_en, bus.err, bus.err_code, bus.count} !== {1'b0, 1'b1, ERR_IMM, 3'd2}) begin
            miscompares++;
            $display("FAIL beq_range: got wen=%b err=%b code=%b cnt=%0d required 0 1 10 2", bus.wr_en, bus.err, bus.err_code, bus.count);
        end
        pulse_clear();
        vectors++;
        if ({bus.count, bus.err, bus.err_code} !== {3'd0, 1'b0, 2'b00}) begin
            miscompares++;
            $display("FAIL clear_idle: got cnt=%0d err=%b code=%b required 0 0 00", bus.count, bus.err, bus.err_code);
        end
    endtask

    task automatic test_formats();
        drive(OPCODE_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        vectors++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 2'd0, 32'h123452B7}) begin
            miscompares++;
            $display("FAIL lui: got wen=%b addr=%0d data=%h required 1 0 123452b7", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        drive(OPCODE_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        vectors++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 2'd1, 32'h008000EF}) begin
            miscompares++;
            $display("FAIL jal: got wen=%b addr=%0d data=%h required 1 1 008000ef", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        drive(OPCODE_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        vectors++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 2'd2, 32'h0020A423}) begin
            miscompares++;
            $display("FAIL sw: got wen=%b addr=%0d data=%h required 1 2 0020a423", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        drive(OPCODE_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        vectors++;
        if ({bus.wr_en, bus.err, bus.err_code, bus.count} !== {1'b0, 1'b1, ERR_IMM, 3'd3}) begin
            miscompares++;
            $display("FAIL jal_odd: got wen=%b err=%b code=%b cnt=%0d required 0 1 10 3", bus.wr_en, bus.err, bus.err_code, bus.count);
        end
        pulse_clear();
    endtask

    task automatic test_bad_opcode();
        drive(5'b11111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        vectors++;
        if ({bus.wr_en, bus.err, bus.err_code} !== {1'b0, 1'b1, ERR_OPCODE}) begin
            miscompares++;
            $display("FAIL bad_op: got wen=%b err=%b code=%b required 0 1 01", bus.wr_en, bus.err, bus.err_code);
        end
        drive(OPCODE_ARITH_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
        vectors++;
        if ({bus.wr_en, bus.err, bus.err_code, bus.count} !== {1'b0, 1'b1, ERR_OPCODE, 3'd0}) begin
            miscompares++;
            $display("FAIL sticky_err: got wen=%b err=%b code=%b cnt=%0d required 0 1 01 0", bus.wr_en, bus.err, bus.err_code, bus.count);
        end
    endtask

    task automatic test_clear_mid_write();
        drive(OPCODE_ARITH_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        drive(OPCODE_ARITH_I, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        clear = 1'b1;
        #1;
        vectors++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 2'd1, 32'h00500113}) begin
            miscompares++;
            $display("FAIL clear_write_kept: got wen=%b addr=%0d data=%h required 1 1 00500113", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        @(negedge clk);
        clear = 1'b0;
        vectors++;
        if ({bus.wr_en, bus.count, bus.err, bus.err_code} !== {1'b0, 3'd0, 1'b0, 2'b00}) begin
            miscompares++;
            $display("FAIL clear_mid_write: got wen=%b cnt=%0d err=%b code=%b required 0 0 0 00", bus.wr_en, bus.count, bus.err, bus.err_code);
        end
        drive(OPCODE_ARITH_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        vectors++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 2'd0, 32'h002081B3}) begin
            miscompares++;
            $display("FAIL after_clear_write: got wen=%b addr=%0d data=%h required 1 0 002081b3", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
    endtask

    task automatic test_back_to_back_full();
        int accepted;
        int writes;
        logic [ADDR_W-1:0] addrs [$];
        accepted = 0;
        writes = 0;
        pulse_clear();
        set_fields(OPCODE_ARITH_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bus.wr_en === 1'b1) begin
                writes++;
                addrs.push_back(bus.wr_addr);
            end
            bus.in_valid = (accepted < 6);
            if (bus.in_valid && bus.in_ready === 1'b1) accepted++;
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (writes !== 4 || accepted !== 4) begin
            miscompares++;
            $display("FAIL full_writes: got writes=%0d accepts=%0d required 4 4", writes, accepted);
        end
        for (int i = 0; i < addrs.size() && i < 4; i++) begin
            vectors++;
            if (addrs[i] !== ADDR_W'(i)) begin
                miscompares++;
                $display("FAIL full_addr%0d: got %0d required %0d", i, addrs[i], i);
            end
        end
        vectors++;
        if ({bus.full, bus.in_ready, bus.count, bus.err} !== {1'b1, 1'b0, 3'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL full_status: got full=%b rdy=%b cnt=%0d err=%b required 1 0 4 0", bus.full, bus.in_ready, bus.count, bus.err);
        end
    endtask

    task automatic test_reset_mid_write();
        pulse_clear();
        drive(5'b11111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        drive(OPCODE_ARITH_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        vectors++;
        if ({bus.wr_en, bus.err} !== {1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL pre_reset: got wen=%b err=%b required 1 1", bus.wr_en, bus.err);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.count, bus.full, bus.err, bus.err_code}
            !== {1'b1, 1'b0, 2'd0, 32'd0, 3'd0, 1'b0, 1'b0, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_mid_write: got rdy=%b wen=%b addr=%0d data=%h cnt=%0d full=%b err=%b code=%b required 1 0 0 0 0 0 0 00",
                     bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.count, bus.full, bus.err, bus.err_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.wr_en, bus.count} !== {1'b0, 3'd0}) begin
            miscompares++;
            $display("FAIL after_reset: got wen=%b cnt=%0d required 0 0", bus.wr_en, bus.count);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_addi();
        test_branch();
        test_formats();
        test_bad_opcode();
        test_clear_mid_write();
        test_back_to_back_full();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
